// File: rtl/seq_math_unit.sv
// Sequential math stage for the TinyQV accelerator: one-cycle logic/add/sub,
// plus iterative multiply and divide that each resolve one bit per clock.
//
//   state   | meaning
//   IDLE    | waiting for start; single-cycle ops complete from here
//   MUL_RUN | shift-add multiply, one multiplier bit per clock
//   DIV_RUN | restoring divide, one quotient bit per clock
module seq_math_unit #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          opcode,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  output logic                div_by_zero
);

  localparam int RW = 2 * DATA_W;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sh;      // multiplier (MUL) or dividend/quotient (DIV)
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] rem;
  logic [RW-1:0]     mcand;
  logic [RW-1:0]     acc;

  logic [RW-1:0]     single_res;
  logic [RW-1:0]     acc_next;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              fits;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  always_comb begin
    single_res = '0;
    case (opcode)
      OP_ADD:  single_res = RW'({1'b0, a} + {1'b0, b});
      OP_SUB:  single_res = RW'(a) - RW'(b);
      OP_AND:  single_res = RW'(a & b);
      OP_OR:   single_res = RW'(a | b);
      OP_XOR:  single_res = RW'(a ^ b);
      default: single_res = '0;
    endcase
  end

  always_comb begin
    acc_next = acc + (sh[0] ? mcand : '0);
    shifted  = {rem, sh[DATA_W-1]};
    trial    = shifted - {1'b0, divisor};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_next = {sh[DATA_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      divisor     <= '0;
      rem         <= '0;
      mcand       <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (opcode == OP_MUL) begin
              state <= MUL_RUN;
              busy  <= 1'b1;
              cnt   <= CW'(DATA_W - 1);
              sh    <= b;
              mcand <= RW'(a);
              acc   <= '0;
            end else if (opcode == OP_DIV && b == '0) begin
              result      <= {a, {DATA_W{1'b1}}};
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else if (opcode == OP_DIV) begin
              state   <= DIV_RUN;
              busy    <= 1'b1;
              cnt     <= CW'(DATA_W - 1);
              sh      <= a;
              divisor <= b;
              rem     <= '0;
            end else begin
              result <= single_res;
              done   <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          sh    <= sh >> 1;
          if (cnt == '0) begin
            result <= acc_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV_RUN: begin
          rem <= rem_next;
          sh  <= quo_next;
          if (cnt == '0) begin
            result <= {rem_next, quo_next};
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
